// File: rtl/divider_share_arbiter.sv
// divider_share_arbiter: round-robin sharing of one divider among N_REQ requesters.
// Define DIVIDER_SHARE_ZERO_BYPASS_EN to answer divide-by-zero locally without using the divider.
module divider_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic [N_REQ-1:0]       i_reqValid,
    output logic [N_REQ-1:0]       o_reqReady,
    input  logic [N_REQ*WIDTH-1:0] i_reqDividend,
    input  logic [N_REQ*WIDTH-1:0] i_reqDivisor,
    output logic                   o_rspValid,
    input  logic                   i_rspReady,
    output logic [ID_W-1:0]        o_rspId,
    output logic [WIDTH-1:0]       o_rspQuotient,
    output logic [WIDTH-1:0]       o_rspRemainder,
    output logic                   o_divBegin,
    output logic [WIDTH-1:0]       o_divDividend,
    output logic [WIDTH-1:0]       o_divDivisor,
    input  logic                   i_divBusy,
    input  logic                   i_divDone,
    input  logic [WIDTH-1:0]       i_divQuotient,
    input  logic [WIDTH-1:0]       i_divRemainder
);
    typedef enum logic [1:0] {S_IDLE, S_BEGIN, S_WAIT, S_RSP} state_t;

    state_t           r_state, w_next;
    logic [ID_W-1:0]  r_ptr, r_id, w_win;
    logic [WIDTH-1:0] r_dividend, r_divisor, r_quot, r_rem, w_dvd, w_dvs;
    logic             w_any, w_fire, w_bypass, w_wait_exit;

    // Scan from the highest offset down so the requester closest to the pointer wins last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_reqValid[(int'(r_ptr) + i) % N_REQ]) begin
                w_any = 1'b1;
                w_win = ID_W'((int'(r_ptr) + i) % N_REQ);
            end
        end
    end

    assign o_reqReady  = (r_state == S_IDLE && !i_divBusy && i_cg && i_rst && w_any) ?
                         (N_REQ'(1) << w_win) : '0;
    assign w_fire      = |o_reqReady;
    assign w_dvd       = i_reqDividend[w_win*WIDTH +: WIDTH];
    assign w_dvs       = i_reqDivisor[w_win*WIDTH +: WIDTH];
    assign w_wait_exit = i_divDone | ~i_divBusy;

`ifdef DIVIDER_SHARE_ZERO_BYPASS_EN
    assign w_bypass = (w_dvs == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_next = w_bypass ? S_RSP : S_BEGIN;
            S_BEGIN: w_next = S_WAIT;
            S_WAIT:  if (w_wait_exit) w_next = S_RSP;
            S_RSP:   if (i_rspReady) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else if (i_cg) begin
            r_state <= w_next;
            if (w_fire) begin
                r_dividend <= w_dvd;
                r_divisor  <= w_dvs;
                r_id       <= w_win;
                r_ptr      <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
                if (w_bypass) begin
                    r_quot <= '1;
                    r_rem  <= w_dvd;
                end
            end
            if (r_state == S_WAIT && w_wait_exit) begin
                r_quot <= i_divQuotient;
                r_rem  <= i_divRemainder;
            end
        end
    end

    assign o_rspValid     = (r_state == S_RSP);
    assign o_rspId        = r_id;
    assign o_rspQuotient  = r_quot;
    assign o_rspRemainder = r_rem;
    assign o_divBegin     = (r_state == S_BEGIN);
    assign o_divDividend  = r_dividend;
    assign o_divDivisor   = r_divisor;
endmodule

// File: tb/tb_divider_share_arbiter.sv
// tb_divider_share_arbiter: directed vectors against a behavioural divider with fixed latency.
module tb_divider_share_arbiter;
    localparam int N = 4, W = 8, DIV_LAT = 5, RSP_LAT = DIV_LAT + 2;

    logic clk = 0, rst_n = 0, cg = 1;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_ready = 0, div_begin;
    logic [1:0] rsp_id;
    logic [W-1:0] rsp_q, rsp_r, div_a, div_b;
    logic m_busy = 0, m_done = 0;
    logic [W-1:0] m_q = '0, m_r = '0;
    int m_cnt = 0, nbeg = 0, total = 0, bad = 0;

    typedef struct {int id; logic [W-1:0] a, b, q, r;} vec_t;
    vec_t tv[6];

    divider_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_cg(cg),
        .i_reqValid(req_valid), .o_reqReady(req_ready),
        .i_reqDividend(req_a), .i_reqDivisor(req_b),
        .o_rspValid(rsp_valid), .i_rspReady(rsp_ready), .o_rspId(rsp_id),
        .o_rspQuotient(rsp_q), .o_rspRemainder(rsp_r),
        .o_divBegin(div_begin), .o_divDividend(div_a), .o_divDivisor(div_b),
        .i_divBusy(m_busy), .i_divDone(m_done),
        .i_divQuotient(m_q), .i_divRemainder(m_r));

    always #5 clk = ~clk;

    // Divider model: not reset by the arbiter, done arrives DIV_LAT cycles after the begin cycle.
    always @(posedge clk) if (cg) begin
        m_done <= 0;
        if (div_begin) begin
            m_busy <= 1;
            m_cnt  <= DIV_LAT - 1;
            m_q    <= (div_b == 0) ? '1 : div_a / div_b;
            m_r    <= (div_b == 0) ? div_a : div_a % div_b;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 0;
                m_done <= 1;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) if (cg && div_begin) nbeg <= nbeg + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        int c = 0;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id] = 1;
        #1;
        while (!req_ready[id] && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!req_ready[id]) check("grant_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        req_valid[id] = 0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 200);
        if (!rsp_valid) check("rsp_timeout", 0, 1);
    endtask

    task automatic accept();
        rsp_ready = 1;
        @(posedge clk);
        #1;
        rsp_ready = 0;
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        int cyc, b0, win, c;
        bit held, seen;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, b0, win, c;
        bit held, seen;
        tv[0] = '{2, 8'd200, 8'd7,   8'd28,  8'd4};
        tv[1] = '{0, 8'd255, 8'd1,   8'd255, 8'd0};
        tv[2] = '{1, 8'd9,   8'd10,  8'd0,   8'd9};
        tv[3] = '{3, 8'd100, 8'd10,  8'd10,  8'd0};
        tv[4] = '{2, 8'd255, 8'd255, 8'd1,   8'd0};
        tv[5] = '{1, 8'd0,   8'd5,   8'd0,   8'd0};

        req_valid[0] = 1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_ctrl", {rsp_valid, div_begin}, 0);
        check("rst_data", {rsp_id, rsp_q, rsp_r, div_a, div_b}, 0);
        req_valid = '0;
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            b0 = nbeg;
            send(tv[i].id, tv[i].a, tv[i].b);
            check("operands", {div_a, div_b}, {tv[i].a, tv[i].b});
            wait_rsp(cyc);
            check("latency", cyc, RSP_LAT);
            check("rsp_id", rsp_id, tv[i].id);
            check("quotient", rsp_q, tv[i].q);
            check("remainder", rsp_r, tv[i].r);
            check("begin_count", nbeg - b0, 1);
            @(negedge clk);
            check("rsp_hold", rsp_valid, 1);
            accept();
        end

        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = W'(20 + 13 * k);
            req_b[k*W +: W] = W'(k + 3);
        end
        req_valid = '1;
        #1;
        for (int j = 0; j < 6; j++) begin
            c = 0;
            while (!(|req_ready) && c < 100) begin
                @(negedge clk);
                c++;
            end
            win = -1;
            for (int k = 0; k < N; k++) if (req_ready[k]) win = k;
            check("rr_onehot", $countones(req_ready), 1);
            check("rr_grant", win, j % N);
            @(posedge clk);
            #1;
            wait_rsp(cyc);
            check("rr_id", rsp_id, j % N);
            check("rr_quot", rsp_q, W'((20 + 13 * (j % N)) / ((j % N) + 3)));
            accept();
        end
        req_valid = '0;

        send(1, 8'd77, 8'd8);
        wait_rsp(cyc);
        req_valid[0] = 1;
        b0 = nbeg;
        held = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_id != 1 || rsp_q != 9 || rsp_r != 5) held = 0;
            if (|req_ready) seen = 1;
        end
        check("bp_stable", held, 1);
        check("bp_no_ready", seen, 0);
        check("bp_no_begin", nbeg - b0, 0);
        req_valid[0] = 0;
        accept();

        send(1, 8'd200, 8'd7);
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_ctrl", {rsp_valid, div_begin, req_ready}, 0);
        check("arst_data", {rsp_id, div_a, div_b}, 0);
        @(negedge clk);
        rst_n = 1;
        req_a[3*W +: W] = 8'd100;
        req_b[3*W +: W] = 8'd10;
        req_valid[3] = 1;
        @(negedge clk);
        check("busy_no_grant", req_ready, 0);
        send(3, 8'd100, 8'd10);
        check("stale_done", rsp_valid, 0);
        wait_rsp(cyc);
        check("post_rst_lat", cyc, RSP_LAT);
        check("post_rst_id", rsp_id, 3);
        check("post_rst_q", rsp_q, 10);
        check("post_rst_r", rsp_r, 0);
        accept();

        b0 = nbeg;
        send(0, 8'd55, 8'd0);
        wait_rsp(cyc);
`ifdef DIVIDER_SHARE_ZERO_BYPASS_EN
        check("zero_lat", cyc, 1);
        check("zero_begin", nbeg - b0, 0);
`else
        check("zero_lat", cyc, RSP_LAT);
        check("zero_begin", nbeg - b0, 1);
`endif
        check("zero_q", rsp_q, 8'hFF);
        check("zero_r", rsp_r, 8'd55);
        check("zero_id", rsp_id, 0);
        accept();

        send(2, 8'd200, 8'd7);
        cg = 0;
        b0 = nbeg;
        held = 1;
        repeat (5) begin
            @(negedge clk);
            if (!div_begin) held = 0;
        end
        check("cg_begin_held", held, 1);
        check("cg_no_issue", nbeg - b0, 0);
        cg = 1;
        wait_rsp(cyc);
        check("cg_issue_once", nbeg - b0, 1);
        check("cg_q", rsp_q, 28);
        check("cg_r", rsp_r, 4);
        check("cg_id", rsp_id, 2);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/divider_share_arbiter.md
Name: divider_share_arbiter

Overview:
Shares one dividerFsm instance between N requesters using round-robin arbitration.
- Accepts one division request at a time from a requester and issues it to the divider.
- Captures the divider result and returns it on a single response channel tagged with the requester index.
- Sits between multiple client blocks and a single dividerFsm in the datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, dividend/divisor/quotient/remainder width; must match the divider
ID_W, 2, response tag width; must equal clog2(N_REQ)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_cg  in  1  clock gate; state holds when 0
i_reqValid  in  N_REQ  per-requester request valid
o_reqReady  out  N_REQ  per-requester accept, one-hot or zero
i_reqDividend  in  N_REQ*WIDTH  flattened dividends; requester k at [k*WIDTH +: WIDTH]
i_reqDivisor  in  N_REQ*WIDTH  flattened divisors, same packing
o_rspValid  out  1  response valid
i_rspReady  in  1  response accept
o_rspId  out  ID_W  index of the requester owning the response
o_rspQuotient  out  WIDTH  captured quotient
o_rspRemainder  out  WIDTH  captured remainder
o_divBegin  out  1  to divider i_begin; single-cycle pulse
o_divDividend  out  WIDTH  to divider i_dividend; registered, stable from BEGIN until capture
o_divDivisor  out  WIDTH  to divider i_divisor; registered, same stability
i_divBusy  in  1  from divider o_busy
i_divDone  in  1  from divider o_done
i_divQuotient  in  WIDTH  from divider o_quotient
i_divRemainder  in  WIDTH  from divider o_remainder

Behaviour:
Reset (i_rst=0, asynchronous):
- State=IDLE; round-robin pointer=0.
- All outputs 0, including o_reqReady, o_rspValid, o_divBegin, data and ID.

All state updates require i_cg=1. When i_cg=0 everything holds, including a pending o_divBegin.

FSM states:
- IDLE:
  - Arbitrate among asserted i_reqValid, starting at pointer and wrapping modulo N_REQ.
  - o_reqReady is combinational: one-hot on the winner, only in IDLE and only when i_divBusy=0.
  - Handshake on valid&ready: latch dividend, divisor and ID; pointer=winner+1 (wrapping N_REQ-1 to 0).
  - Next state BEGIN.
  - With no requests, stay in IDLE.
- BEGIN:
  - o_divBegin=1 for exactly one cycle; next state WAIT.
- WAIT:
  - Leave on the first cycle with i_divDone=1, or i_divBusy=0 seen at least one cycle after BEGIN.
  - On exit, capture quotient and remainder into response registers; next state RSP.
- RSP:
  - o_rspValid=1; ID and data held stable until i_rspReady=1.
  - On i_rspReady=1 go to IDLE. o_rspValid drops the next cycle.
  - New requests are not accepted during RSP; the response register is single-entry.

Timing and ordering:
- Minimum latency: request handshake to o_rspValid = divider latency + 2 cycles.
- A request accepted in IDLE cannot change the registered operands.
- Requesters must hold valid and data until ready (AXI-style). A drop of valid before ready is allowed and is simply not granted.
- Simultaneous requests: a requester granted in IDLE is not favoured again until all others have had a grant opportunity.

Corner cases:
- i_divBusy=1 while in IDLE (foreign use or stale): no grant.
- Reset mid-operation: immediate return to IDLE. A divider already running is not cancelled; its later i_divDone is ignored because the FSM is not in WAIT.

Optional Feature:
Macro DIVIDER_SHARE_ZERO_BYPASS_EN.
- Defined: a request with divisor==0 goes IDLE->RSP directly, without pulsing o_divBegin.
  - Response: quotient = all ones ({WIDTH{1'b1}}), remainder = dividend.
  - Latency from handshake to o_rspValid is 1 cycle.
- Undefined: divisor 0 is issued to the divider like any other request, and the divider's result is returned unmodified.

Test Plan:
- Single request: requester 2 sends 200/7 -> one o_divBegin pulse; response ID=2, quotient 28, remainder 4; o_rspValid held until i_rspReady.
- All 4 requesters continuously valid, pointer 0 -> grant order 0,1,2,3,0,1; each response ID matches the order; no requester is granted twice before the others.
- Backpressure: i_rspReady=0 for 10 cycles -> o_rspValid, o_rspId and data stable; o_reqReady all 0; no further o_divBegin.
- Reset asserted during WAIT -> all outputs 0 asynchronously; a later i_divDone produces no response; next request (100/10) returns quotient 10, remainder 0.
- Divisor 0 (dividend 55): with DIVIDER_SHARE_ZERO_BYPASS_EN -> no o_divBegin, quotient 8'hFF, remainder 55 one cycle after the handshake; without it -> the divider's result is passed through.
- i_cg=0 held for 5 cycles in BEGIN -> o_divBegin stays pending and is issued exactly once after i_cg returns to 1.
